// File: rtl/craps_pkg.sv
// Shared types and constants for the craps datapath: die/sum types, game sums, die stepping.
package craps_pkg;

    localparam int unsigned DIE_W = 3;
    localparam int unsigned SUM_W = 4;

    typedef logic [DIE_W-1:0] die_t;
    typedef logic [SUM_W-1:0] sum_t;

    localparam die_t DIE_MIN      = 3'd1;
    localparam die_t DIE_MAX      = 3'd6;
    localparam sum_t SUM_SEVEN    = 4'd7;
    localparam sum_t SUM_ELEVEN   = 4'd11;
    localparam sum_t SUM_CRAPS_2  = 4'd2;
    localparam sum_t SUM_CRAPS_3  = 4'd3;
    localparam sum_t SUM_CRAPS_12 = 4'd12;

    function automatic logic die_legal(input die_t d);
        return (d >= DIE_MIN) && (d <= DIE_MAX);
    endfunction

    // Next face on an advance; 6 and any illegal value both land on 1.
    function automatic die_t die_next(input die_t d);
        return (d >= DIE_MAX || d < DIE_MIN) ? DIE_MIN : d + DIE_W'(1);
    endfunction

    function automatic logic is_craps(input sum_t s);
        return (s == SUM_CRAPS_2) || (s == SUM_CRAPS_3) || (s == SUM_CRAPS_12);
    endfunction

endpackage

// File: rtl/craps_datapath_if.sv
// Controller <-> datapath link: dice/point commands one way, button level and sum flags the other.
interface craps_datapath_if;

    logic inc;
    logic ld;
    logic sync_x;
    logic eq6;
    logic eq7;
    logic eq11;
    logic eq;

    modport master (output inc, ld, input sync_x, eq6, eq7, eq11, eq);
    modport slave  (input inc, ld, output sync_x, eq6, eq7, eq11, eq);

endinterface

// File: rtl/craps_datapath_button_sync.sv
// Roll-button synchroniser chain; define CRAPS_DEBOUNCE_EN to add a stable-level debounce counter.
module button_sync #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic sync_x
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("button_sync: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end

`ifdef CRAPS_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_cnt;

    // Toggle on the edge where the count would reach DEBOUNCE_CYCLES, so a held
    // level costs exactly DEBOUNCE_CYCLES cycles beyond the synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt <= '0;
            sync_x <= 1'b0;
        end else if (sync_q[SYNC_STAGES-1] == sync_x) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt <= '0;
            sync_x <= ~sync_x;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end
`else
    assign sync_x = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/craps_datapath.sv
// Craps datapath: button sync, odometer dice, point register, sum flags, saturating roll counter.
// Optional debounce in the button path is enabled by defining CRAPS_DEBOUNCE_EN.
module craps_datapath
    import craps_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_raw,
    craps_datapath_if.slave  ctrl,
    output die_t             die_a,
    output die_t             die_b,
    output sum_t             sum,
    output sum_t             point,
    output logic [CNT_W-1:0] roll_count
);

    logic sync_x;
    logic sync_d;
    logic sync_rise;

    button_sync #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button_sync (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .sync_x  (sync_x)
    );

    assign ctrl.sync_x = sync_x;

    // Odometer: die_b steps only when die_a wraps 6 -> 1; an illegal die_b is repaired on any advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            die_a <= DIE_MIN;
            die_b <= DIE_MIN;
        end else if (ctrl.inc) begin
            die_a <= die_next(die_a);
            if (die_a == DIE_MAX || !die_legal(die_b)) begin
                die_b <= die_next(die_b);
            end
        end
    end

    assign sum = SUM_W'(die_a) + SUM_W'(die_b);

    // Captures the sum presented this cycle, i.e. before any simultaneous advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        point <= '0;
        else if (ctrl.ld) point <= sum;
    end

    assign ctrl.eq6  = is_craps(sum);
    assign ctrl.eq7  = (sum == SUM_SEVEN);
    assign ctrl.eq11 = (sum == SUM_ELEVEN);
    assign ctrl.eq   = (sum == point);

    assign sync_rise = sync_x & ~sync_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_d     <= 1'b0;
            roll_count <= '0;
        end else begin
            sync_d <= sync_x;
            if (sync_rise && roll_count != '1) begin
                roll_count <= roll_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/craps_datapath.md
Name: craps_datapath

Overview:
- Datapath partner of the craps game controller. It sits upstream of the controller for `sync_x` and the comparison flags, and downstream of it for `inc` and `ld`.
- Synchronises (and optionally debounces) the raw roll button into `sync_x`.
- Runs two free-running dice counters while `inc` is high and latches the point on `ld`.
- Produces the sum comparisons `eq6`, `eq7`, `eq11` and `eq` that the controller consumes.

Parameters:
- SYNC_STAGES, 2: number of flip-flops in the button synchroniser chain; minimum 2.
- DEBOUNCE_CYCLES, 16: number of stable clock cycles required before `sync_x` changes. Used only when the debounce macro is defined.
- CNT_W, 8: width of the roll counter.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- btn_raw  in  1  asynchronous roll button, active-high
- inc  in  1  from controller: advance dice this cycle
- ld  in  1  from controller: capture current sum into the point register
- sync_x  out  1  synchronised (and optionally debounced) button level, to controller
- die_a  out  3  first die value, 1..6
- die_b  out  3  second die value, 1..6
- sum  out  4  die_a + die_b, 2..12
- point  out  4  latched point value
- eq6  out  1  craps: sum is 2, 3 or 12
- eq7  out  1  sum == 7
- eq11  out  1  sum == 11
- eq  out  1  sum == point
- roll_count  out  CNT_W  number of button presses, saturating

Behaviour:
- Reset values (asynchronous, active-high): synchroniser flops 0, `sync_x` 0, `die_a` 1, `die_b` 1, `point` 0, `roll_count` 0.
- Consequences of reset: `sum` = 2, so `eq6` = 1 and `eq7`/`eq11`/`eq` = 0 after reset.
- Synchroniser:
  - `btn_raw` passes through SYNC_STAGES flops.
  - Without debounce, `sync_x` equals the last stage.
  - Latency: a `btn_raw` edge shows up on `sync_x` after SYNC_STAGES rising edges.
- Dice counters (odometer):
  - On a clk edge with `inc`=1, `die_a` increments; 6 wraps to 1.
  - `die_b` increments only in the cycle where `die_a` wraps (6 to 1). `die_b` also wraps 6 to 1.
  - Both at 6 with `inc`=1 gives 1,1 on the next cycle.
  - `inc`=0 holds both dice.
  - Values 0 and 7 are never produced. If a die ever holds an illegal value, the next `inc` forces that die to 1.
- Sum and flags:
  - `sum` is combinational from the registered dice, 4 bits unsigned, no overflow possible (maximum 12).
  - `eq6`, `eq7`, `eq11` and `eq` are combinational from `sum` and `point`. Zero latency from the dice registers; glitch-free at the controller sampling edge.
- Point register:
  - On a clk edge with `ld`=1, `point` takes the current `sum`; otherwise it holds.
  - `ld` and `inc` in the same cycle: `point` captures the pre-increment `sum`.
  - No clear other than reset; a new game overwrites it on the next `ld`.
- Roll counter:
  - Increments on every rising edge of `sync_x`, detected with a one-cycle registered delay.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous). A button held through reset release produces a `sync_x` rise SYNC_STAGES cycles later, and that rise is counted.

Optional Feature:
- Macro: CRAPS_DEBOUNCE_EN.
- Defined:
  - A counter of width ceil(log2(DEBOUNCE_CYCLES+1)) compares the synchroniser output with `sync_x`.
  - The counter clears whenever the two are equal, and increments while they differ.
  - When it reaches DEBOUNCE_CYCLES, `sync_x` toggles and the counter clears.
  - Any bounce shorter than DEBOUNCE_CYCLES is suppressed.
  - Total latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Undefined: no debounce logic is built; `sync_x` is the raw synchroniser output.

Decomposition:
- Package `craps_pkg`:
  - die type (3 bits) and sum type (4 bits)
  - constants DIE_MIN=1, DIE_MAX=6, SUM_SEVEN=7, SUM_ELEVEN=11, SUM_CRAPS_2=2, SUM_CRAPS_3=3, SUM_CRAPS_12=12
- Sub-module `button_sync`:
  - contains the synchroniser chain and the `ifdef CRAPS_DEBOUNCE_EN` debounce counter
  - ports: clk, reset, btn_raw, sync_x
- Dice counters, point register and roll counter stay in `craps_datapath`.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle → `die_a`=1, `die_b`=1, `sum`=2, `eq6`=1, `point`=0, `roll_count`=0 immediately.
- Dice odometer: hold `inc`=1 for 35 cycles from reset → `die_a`=6, `die_b`=6, `sum`=12, `eq6`=1. One more `inc` cycle → 1,1.
- Wrap carry: from 6,1 apply one `inc` → 1,2, `sum`=3, `eq6`=1. Set dice to 3,4 → `sum`=7, `eq7`=1; 5,6 → `sum`=11, `eq11`=1.
- Point latch: with `sum`=8, pulse `ld` together with `inc` → `point`=8 (pre-increment sum). Step dice to 2,6 → `eq`=1; 3,6 → `eq`=0.
- Synchroniser (macro undefined): raise `btn_raw` → `sync_x`=1 exactly 2 cycles later, `roll_count`=1. Five presses → `roll_count`=5. With CNT_W=2, five presses → 3 (saturated).
- Debounce (CRAPS_DEBOUNCE_EN, DEBOUNCE_CYCLES=16): apply 10-cycle pulses → `sync_x` stays 0. Hold high → `sync_x`=1 after 18 cycles, `roll_count` +1.
